// File: rtl/apb_pkg.sv
// Shared types and limits for the APB memory slave.
package apb_pkg;

  typedef enum logic {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_t;

  // Largest supported number of wait states (4-bit counter).
  localparam int APB_MAX_WAIT = 15;

  // Width of a down-counter that must hold values 0..max_val. Never below 1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Word-organised storage with byte-enable synchronous write and async read.
// The storage has no reset, so its contents survive a bus reset.
module apb_mem_bank
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int BAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [BAW-1:0]        i_waddr,
  input  logic [NB-1:0]         i_wbe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [BAW-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read port is combinational so data can be captured on the setup edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB memory slave with byte strobes, fixed wait states and slave error for
// out-of-range or misaligned addresses. Read data is captured at the setup
// edge and presented only in the ready cycle.
module apb_mem_slave_ws
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int AL         = (NB > 1) ? $clog2(NB) : 0,
  localparam int IW         = ADDR_WIDTH - AL,
  localparam int BAW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW         = cnt_width(WAIT_STATES)
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  pen,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [NB-1:0]         pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  apb_state_t            r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [IW-1:0]         w_idx;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_err;
  logic                  w_setup;
  logic                  w_done;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Address decode for the setup phase (uses the live bus address).
  assign w_idx       = paddr[ADDR_WIDTH-1:AL];
  assign w_range_err = (32'(w_idx) >= 32'(DEPTH));

  if (AL > 0) begin : g_align
    assign w_misalign = |paddr[AL-1:0];
  end else begin : g_noalign
    assign w_misalign = 1'b0;
  end

  assign w_err   = w_range_err | w_misalign;
  assign w_setup = (r_state == APB_IDLE) & psel & ~pen;
  assign w_done  = (r_state == APB_ACCESS) & psel & pen & (r_cnt == '0);

  // Reset beats a completing access so an interrupted write never lands.
  assign w_we = w_done & r_write & ~r_err & ~prst;

  apb_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clk     (pclk),
    .i_we    (w_we),
    .i_waddr (r_idx[BAW-1:0]),
    .i_wbe   (r_strb),
    .i_wdata (r_wdata),
    .i_raddr (w_idx[BAW-1:0]),
    .o_rdata (w_rdata)
  );

  // FSM, wait counter, latched transfer attributes and read-data register.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state  <= APB_IDLE;
      r_cnt    <= '0;
      r_prdata <= '0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
    end else begin
      case (r_state)
        APB_IDLE: begin
          if (w_setup) begin
            r_state  <= APB_ACCESS;
            r_cnt    <= CW'(WAIT_STATES);
            r_idx    <= w_idx;
            r_write  <= pwrite;
            r_wdata  <= pwdata;
            r_strb   <= pstrb;
            r_err    <= w_err;
            r_prdata <= (!pwrite && !w_err) ? w_rdata : '0;
          end else begin
            r_prdata <= '0;
          end
        end
        APB_ACCESS: begin
          if (!psel) begin
            // Master abandoned the transfer: nothing is written.
            r_state  <= APB_IDLE;
            r_cnt    <= '0;
            r_prdata <= '0;
          end else if (pen) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_state  <= APB_IDLE;
              r_prdata <= '0;
            end
          end
        end
        default: begin
          r_state  <= APB_IDLE;
          r_cnt    <= '0;
          r_prdata <= '0;
        end
      endcase
    end
  end

  // Outputs decode purely from registers; data is masked outside ready.
  assign pready  = (r_state == APB_ACCESS) & (r_cnt == '0);
  assign pslverr = pready & r_err;
  assign prdata  = pready ? r_prdata : '0;

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench: three slave instances (zero-wait, 3-wait with wide address,
// 2-wait) driven from a shared bus with a per-instance select.
module tb_apb_mem_slave_ws;

  logic        pclk = 1'b0;
  logic        prst;
  logic [9:0]  paddr;
  logic        pwrite;
  logic [2:0]  psel;
  logic        pen;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_a  [3];
  logic        pready_a  [3];
  logic        pslverr_a [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  apb_mem_slave_ws #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .prst(prst), .paddr(paddr[7:0]), .pwrite(pwrite), .psel(psel[0]),
    .pen(pen), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[0]),
    .pready(pready_a[0]), .pslverr(pslverr_a[0]));

  apb_mem_slave_ws #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut1 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwrite(pwrite), .psel(psel[1]),
    .pen(pen), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[1]),
    .pready(pready_a[1]), .pslverr(pslverr_a[1]));

  apb_mem_slave_ws #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut2 (
    .pclk(pclk), .prst(prst), .paddr(paddr[7:0]), .pwrite(pwrite), .psel(psel[2]),
    .pen(pen), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[2]),
    .pready(pready_a[2]), .pslverr(pslverr_a[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer starting at the next falling edge; no trailing idle so
  // consecutive calls run back-to-back. Returns data/err seen in ready cycle.
  task automatic xfer(input int d, input logic w, input logic [9:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err,
                      output int waits, output logic zero_ok);
    @(negedge pclk);
    psel = '0; psel[d] = 1'b1; pen = 1'b0;
    pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    pen = 1'b1;
    waits = 0; zero_ok = 1'b1;
    while (!pready_a[d] && waits < 40) begin
      if (prdata_a[d] !== 32'h0 || pslverr_a[d] !== 1'b0) zero_ok = 1'b0;
      waits++;
      @(negedge pclk);
    end
    rd  = prdata_a[d];
    err = pslverr_a[d];
  endtask

  task automatic idle();
    @(negedge pclk);
    psel = '0; pen = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        zok;
    int          waits;

    //         d  w     addr    wdata         strb   exp_rd        err   waits
    vecs[0]  = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0};
    vecs[1]  = '{0, 1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0};
    vecs[2]  = '{0, 1'b1, 10'h010, 32'h11223344, 4'h5, 32'h0,        1'b0, 0};
    vecs[3]  = '{0, 1'b0, 10'h010, 32'h0,        4'hF, 32'hDE22BE44, 1'b0, 0};
    vecs[4]  = '{0, 1'b0, 10'h011, 32'h0,        4'h0, 32'h0,        1'b1, 0};
    vecs[5]  = '{0, 1'b1, 10'h011, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 0};
    vecs[6]  = '{0, 1'b0, 10'h010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 0};
    vecs[7]  = '{0, 1'b1, 10'h004, 32'hA5A55A5A, 4'hF, 32'h0,        1'b0, 0};
    vecs[8]  = '{0, 1'b0, 10'h004, 32'h0,        4'h0, 32'hA5A55A5A, 1'b0, 0};
    vecs[9]  = '{1, 1'b1, 10'h010, 32'h0F0F0F0F, 4'hF, 32'h0,        1'b0, 3};
    vecs[10] = '{1, 1'b0, 10'h010, 32'h0,        4'h0, 32'h0F0F0F0F, 1'b0, 3};
    vecs[11] = '{1, 1'b0, 10'h100, 32'h0,        4'h0, 32'h0,        1'b1, 3};
    vecs[12] = '{1, 1'b1, 10'h100, 32'h12345678, 4'hF, 32'h0,        1'b1, 3};
    vecs[13] = '{2, 1'b1, 10'h020, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 2};
    vecs[14] = '{2, 1'b1, 10'h008, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0, 2};

    prst = 1'b1; psel = '0; pen = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready%0d", i),  32'(pready_a[i]),  32'h0);
      chk($sformatf("rst_pslverr%0d", i), 32'(pslverr_a[i]), 32'h0);
      chk($sformatf("rst_prdata%0d", i),  prdata_a[i],       32'h0);
    end
    prst = 1'b0;

    // Table runs fully back-to-back (no idle cycles between transfers).
    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].st, rd, err, waits, zok);
      chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
      chk($sformatf("v%0d_wait_quiet", i), 32'(zok), 32'h1);
    end
    idle();

    // Reset during the second access cycle of a 2-wait write.
    @(negedge pclk);
    psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 10'h020;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(negedge pclk);
    pen = 1'b1;
    chk("rstmid_acc1_pready", 32'(pready_a[2]), 32'h0);
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    chk("rstmid_pready", 32'(pready_a[2]), 32'h0);
    chk("rstmid_prdata", prdata_a[2], 32'h0);
    prst = 1'b0; psel = '0; pen = 1'b0;
    xfer(2, 1'b0, 10'h020, 32'h0, 4'h0, rd, err, waits, zok);
    chk("rstmid_word_kept", rd, 32'hCAFEF00D);
    chk("rstmid_next_waits", 32'(waits), 32'h2);
    idle();

    // Master drops psel mid-access: write must not land, slave back to idle.
    @(negedge pclk);
    psel = 3'b100; pen = 1'b0; pwrite = 1'b1; paddr = 10'h008;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    pen = 1'b1;
    @(negedge pclk);
    psel = '0; pen = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 32'(pready_a[2]), 32'h0);
    chk("abort_prdata", prdata_a[2], 32'h0);
    xfer(2, 1'b0, 10'h008, 32'h0, 4'h0, rd, err, waits, zok);
    chk("abort_word_kept", rd, 32'h0BADC0DE);
    chk("abort_next_waits", 32'(waits), 32'h2);
    chk("abort_next_err", 32'(err), 32'h0);
    idle();

    // Stray pen without setup is ignored by an idle slave.
    @(negedge pclk);
    psel = 3'b001; pen = 1'b1; pwrite = 1'b0; paddr = 10'h004;
    @(negedge pclk);
    chk("stray_pen_pready", 32'(pready_a[0]), 32'h0);
    idle();

    repeat (2) @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
